// File: rtl/rfid_tag_auth.sv
// Validates ASCII-hex RFID reader frames from an 8N1 UART stream and compares the tag ID to AUTH_ID.
// Emits one rf_pulse per card presentation; repeated frames inside the holdoff window are suppressed.
module rfid_tag_auth #(
  parameter int          CLK_HZ         = 100000000,
  parameter int          BAUD           = 9600,
  parameter logic [39:0] AUTH_ID        = 40'h0400B3E1F2,
  parameter int          HOLDOFF_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        rf_pulse,
  output logic        id_valid,
  output logic        id_match,
  output logic [39:0] tag_id,
  output logic        frame_err
);

  localparam int BIT_T  = CLK_HZ / BAUD;
  localparam int HALF_T = BIT_T / 2;
  localparam int CW     = $clog2(BIT_T + 1);
  localparam int HW     = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_T - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_T - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_DATA, P_ETX} p_state_t;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            byte_stb, byte_err;

  p_state_t        p_state_q, p_state_d;
  logic [47:0]     sr_q, sr_d;
  logic [3:0]      dcnt_q, dcnt_d;
  logic            accept, perr;

  logic [HW-1:0]   hold_q;
  logic            rf_pulse_q, id_valid_q, id_match_q, frame_err_q;
  logic [39:0]     tag_id_q;

  logic [4:0]      hex;
  logic [39:0]     rx_id;
  logic            cks_ok, id_is_auth;

  // Returns {valid, nibble}; letters share the low nibble between cases.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  // UART receiver: edge-triggered start so a dropped byte re-arms only after the line returns high.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    byte_stb   = 1'b0;
    byte_err   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d  = '0;
          data_d = {rx_sync_q, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) byte_stb = 1'b1;
          else           byte_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign hex        = hex_decode(data_q);
  assign rx_id      = sr_q[47:8];
  assign cks_ok     = (sr_q[47:40] ^ sr_q[39:32] ^ sr_q[31:24] ^ sr_q[23:16] ^ sr_q[15:8]) == sr_q[7:0];
  assign id_is_auth = (rx_id == AUTH_ID);

  // Frame parser: acts on the stop-bit sample itself so outputs land one cycle later.
  always_comb begin
    p_state_d = p_state_q;
    sr_d      = sr_q;
    dcnt_d    = dcnt_q;
    accept    = 1'b0;
    perr      = 1'b0;
    if (byte_err) begin
      p_state_d = P_IDLE;
    end else if (byte_stb) begin
      case (p_state_q)
        P_IDLE: begin
          if (data_q == 8'h02) begin
            p_state_d = P_DATA;
            dcnt_d    = '0;
            sr_d      = '0;
          end
        end
        P_DATA: begin
          if (data_q == 8'h02) begin
            dcnt_d = '0;
            sr_d   = '0;
          end else if (hex[4]) begin
            sr_d = {sr_q[43:0], hex[3:0]};
            if (dcnt_q == 4'd11) begin
              dcnt_d    = '0;
              p_state_d = P_ETX;
            end else begin
              dcnt_d = dcnt_q + 4'd1;
            end
          end else begin
            perr      = 1'b1;
            p_state_d = P_IDLE;
          end
        end
        P_ETX: begin
          p_state_d = P_IDLE;
          if (data_q == 8'h03 && cks_ok) accept = 1'b1;
          else                           perr   = 1'b1;
        end
        default: p_state_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      p_state_q   <= P_IDLE;
      sr_q        <= '0;
      dcnt_q      <= '0;
      hold_q      <= '0;
      rf_pulse_q  <= 1'b0;
      id_valid_q  <= 1'b0;
      id_match_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tag_id_q    <= '0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      p_state_q   <= p_state_d;
      sr_q        <= sr_d;
      dcnt_q      <= dcnt_d;
      id_valid_q  <= accept;
      frame_err_q <= byte_err | perr;
      rf_pulse_q  <= accept && id_is_auth && (hold_q == '0);
      if (accept) begin
        tag_id_q   <= rx_id;
        id_match_q <= id_is_auth;
      end
      // Any authorised read restarts the window, so a card left on the reader never re-fires.
      if (accept && id_is_auth) hold_q <= HOLD_LOAD;
      else if (hold_q != '0)    hold_q <= hold_q - 1'b1;
    end
  end

  assign rf_pulse  = rf_pulse_q;
  assign id_valid  = id_valid_q;
  assign id_match  = id_match_q;
  assign tag_id    = tag_id_q;
  assign frame_err = frame_err_q;

endmodule
